// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for a 5-stage pipeline. Three hazard sources
// are merged into one set of stage write-enables and bubble/flush controls:
//   - load-use hazard        : one-cycle bubble into ID/EX, front end held
//   - taken branch in EX     : squash IF/ID and ID/EX, PC loads the target
//   - multi-cycle mul/div    : front end frozen for MUL_CYCLES-1 cycles
// Saturating statistics counters record stall cycles and branch flushes.
//
// Parameters
//   MUL_CYCLES : total EX occupancy of a mul/div instruction (2..255)
//   CNT_W      : width of the statistics counters
//
// Ports
//   Clk            in   clock, all state updates on rising edge
//   Rst            in   synchronous active-high reset
//   MemRead_EX     in   instruction in EX is a load
//   RT_EX          in   load destination register in EX
//   RS_ID          in   rs field of the instruction in ID
//   RT_ID          in   rt field of the instruction in ID
//   UsesRT_ID      in   ID instruction reads rt as a source
//   BranchTaken_EX in   branch/jump in EX resolved taken this cycle
//   MulStart_EX    in   instruction in EX is mul/div
//   PCWrite        out  PC update enable
//   IFIDWrite      out  IF/ID register write enable
//   IDEXWrite      out  ID/EX register write enable
//   IDEX_Bubble    out  load NOP into ID/EX
//   EXMEM_Bubble   out  load NOP into EX/MEM
//   FlushIF        out  zero IF/ID contents
//   MulDone        out  mul/div result valid this cycle
//   StallCycles    out  saturating count of cycles with PCWrite=0
//   FlushCount     out  saturating count of branch flushes
//
// Control outputs are combinational from state, mcnt and inputs; only the
// state, the mul down-counter and the statistics counters are registered.
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             MemRead_EX,
    input  logic [4:0]       RT_EX,
    input  logic [4:0]       RS_ID,
    input  logic [4:0]       RT_ID,
    input  logic             UsesRT_ID,
    input  logic             BranchTaken_EX,
    input  logic             MulStart_EX,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Bubble,
    output logic             FlushIF,
    output logic             MulDone,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    // The entry cycle is the first frozen cycle, and the MulDone cycle is not
    // frozen, so the counter covers the remaining MUL_CYCLES-2 frozen cycles.
    localparam logic [7:0] MCNT_INIT = 8'(MUL_CYCLES - 2);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       mcnt_r;
    logic [7:0]       mcnt_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             lu_s;
    logic             flush_evt_s;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    // Register 0 is hardwired to zero and never creates a dependency.
    always_comb begin
        lu_s = MemRead_EX && (RT_EX != 5'd0) &&
               ((RT_EX == RS_ID) || (UsesRT_ID && (RT_EX == RT_ID)));
    end

    // Next-state, mul down-counter and pipeline control outputs.
    always_comb begin
        state_nxt_s  = state_r;
        mcnt_nxt_s   = mcnt_r;
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IDEXWrite    = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        FlushIF      = 1'b0;
        MulDone      = 1'b0;
        flush_evt_s  = 1'b0;

        if (Rst) begin
            // Hold every stage and inject NOPs while reset is applied; an
            // in-flight mul/div is abandoned without a MulDone pulse.
            state_nxt_s  = RUN;
            mcnt_nxt_s   = 8'd0;
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEXWrite    = 1'b0;
            IDEX_Bubble  = 1'b1;
            EXMEM_Bubble = 1'b1;
        end else begin
            case (state_r)
                RUN: begin
                    if (BranchTaken_EX) begin
                        // Wrong-path instructions in IF and ID are squashed, so
                        // any load-use hazard they raise is irrelevant.
                        FlushIF     = 1'b1;
                        IDEX_Bubble = 1'b1;
                        flush_evt_s = 1'b1;
                    end else if (MulStart_EX) begin
                        PCWrite      = 1'b0;
                        IFIDWrite    = 1'b0;
                        IDEXWrite    = 1'b0;
                        EXMEM_Bubble = 1'b1;
                        mcnt_nxt_s   = MCNT_INIT;
                        state_nxt_s  = MUL_WAIT;
                    end else if (lu_s) begin
                        // The bubble clears MemRead_EX next cycle, so this
                        // stall lasts exactly one cycle.
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                MUL_WAIT: begin
                    if (mcnt_r != 8'd0) begin
                        PCWrite      = 1'b0;
                        IFIDWrite    = 1'b0;
                        IDEXWrite    = 1'b0;
                        EXMEM_Bubble = 1'b1;
                        mcnt_nxt_s   = mcnt_r - 8'd1;
                    end else begin
                        // Result cycle: front end released; a MulStart_EX still
                        // high here belongs to the finishing op and is ignored.
                        MulDone     = 1'b1;
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    mcnt_nxt_s  = 8'd0;
                end
            endcase
        end
    end

    // State, mul down-counter and saturating statistics counters.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r     <= RUN;
            mcnt_r      <= 8'd0;
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            mcnt_r  <= mcnt_nxt_s;
            if (!PCWrite) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign StallCycles = stall_cnt_r;
    assign FlushCount  = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// Self-checking bench for pipeline_stall_controller (MUL_CYCLES=4, CNT_W=4).
// A table of single-cycle vectors covers load-use, branch and mul sequencing;
// hand-written sequences cover reset mid-mul and counter saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    localparam int MUL_CYCLES = 4;
    localparam int CNT_W      = 4;

    // Control output groups, packed as
    // {PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble, EXMEM_Bubble, FlushIF, MulDone}
    localparam logic [6:0] C_DEF = 7'b1110000;
    localparam logic [6:0] C_RST = 7'b0001100;
    localparam logic [6:0] C_LU  = 7'b0011000;
    localparam logic [6:0] C_BR  = 7'b1111010;
    localparam logic [6:0] C_MUL = 7'b0000100;
    localparam logic [6:0] C_DON = 7'b1110001;

    logic             Clk;
    logic             Rst;
    logic             MemRead_EX;
    logic [4:0]       RT_EX;
    logic [4:0]       RS_ID;
    logic [4:0]       RT_ID;
    logic             UsesRT_ID;
    logic             BranchTaken_EX;
    logic             MulStart_EX;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEXWrite;
    logic             IDEX_Bubble;
    logic             EXMEM_Bubble;
    logic             FlushIF;
    logic             MulDone;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCount;

    int n_cmp;
    int n_fail;

    pipeline_stall_controller #(
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .MemRead_EX     (MemRead_EX),
        .RT_EX          (RT_EX),
        .RS_ID          (RS_ID),
        .RT_ID          (RT_ID),
        .UsesRT_ID      (UsesRT_ID),
        .BranchTaken_EX (BranchTaken_EX),
        .MulStart_EX    (MulStart_EX),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IDEXWrite      (IDEXWrite),
        .IDEX_Bubble    (IDEX_Bubble),
        .EXMEM_Bubble   (EXMEM_Bubble),
        .FlushIF        (FlushIF),
        .MulDone        (MulDone),
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [4:0] rt_ex;
        logic [4:0] rs_id;
        logic [4:0] rt_id;
        logic       uses_rt;
        logic       br;
        logic       mul;
        logic [6:0] ctl;
        logic [3:0] stall;
        logic [3:0] flush;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rst, input logic mr, input logic [4:0] rt_ex,
                                input logic [4:0] rs_id, input logic [4:0] rt_id,
                                input logic uses_rt, input logic br, input logic mul,
                                input logic [6:0] ctl, input logic [3:0] stall,
                                input logic [3:0] flush);
        vec_t v;
        v.rst = rst; v.mr = mr; v.rt_ex = rt_ex; v.rs_id = rs_id; v.rt_id = rt_id;
        v.uses_rt = uses_rt; v.br = br; v.mul = mul;
        v.ctl = ctl; v.stall = stall; v.flush = flush;
        return v;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble, EXMEM_Bubble, FlushIF, MulDone};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s[%0d]: got 'h%0h, expected 'h%0h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MemRead_EX = 1'b0; RT_EX = 5'd0; RS_ID = 5'd0; RT_ID = 5'd0;
        UsesRT_ID = 1'b0; BranchTaken_EX = 1'b0; MulStart_EX = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        Rst = 1'b1;
        next_cycle();
        next_cycle();
        Rst = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        Rst    = 1'b1;
        idle_inputs();

        //            rst  mr   rtex  rsid  rtid  uses br   mul   ctl    stall  flush
        vecs[0]  = mk(1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_RST, 4'd0, 4'd0);
        vecs[1]  = mk(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_DEF, 4'd0, 4'd0);
        vecs[2]  = mk(1'b0,1'b1,5'd5, 5'd5, 5'd0, 1'b0,1'b0,1'b0, C_LU,  4'd0, 4'd0);
        vecs[3]  = mk(1'b0,1'b0,5'd5, 5'd5, 5'd0, 1'b0,1'b0,1'b0, C_DEF, 4'd1, 4'd0);
        vecs[4]  = mk(1'b0,1'b1,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0, C_DEF, 4'd1, 4'd0);
        vecs[5]  = mk(1'b0,1'b1,5'd7, 5'd3, 5'd7, 1'b0,1'b0,1'b0, C_DEF, 4'd1, 4'd0);
        vecs[6]  = mk(1'b0,1'b1,5'd7, 5'd3, 5'd7, 1'b1,1'b0,1'b0, C_LU,  4'd1, 4'd0);
        vecs[7]  = mk(1'b0,1'b0,5'd7, 5'd3, 5'd7, 1'b1,1'b0,1'b0, C_DEF, 4'd2, 4'd0);
        vecs[8]  = mk(1'b0,1'b1,5'd5, 5'd5, 5'd0, 1'b0,1'b1,1'b0, C_BR,  4'd2, 4'd0);
        vecs[9]  = mk(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_DEF, 4'd2, 4'd1);
        vecs[10] = mk(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_MUL, 4'd2, 4'd1);
        vecs[11] = mk(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_MUL, 4'd3, 4'd1);
        vecs[12] = mk(1'b0,1'b1,5'd5, 5'd5, 5'd0, 1'b0,1'b1,1'b1, C_MUL, 4'd4, 4'd1);
        vecs[13] = mk(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_DON, 4'd5, 4'd1);
        vecs[14] = mk(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b1, C_MUL, 4'd5, 4'd1);
        vecs[15] = mk(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_MUL, 4'd6, 4'd1);
        vecs[16] = mk(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_MUL, 4'd7, 4'd1);
        vecs[17] = mk(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_DON, 4'd8, 4'd1);
        vecs[18] = mk(1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0, C_DEF, 4'd8, 4'd1);

        do_reset();

        // Table-driven single-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            Rst            = vecs[i].rst;
            MemRead_EX     = vecs[i].mr;
            RT_EX          = vecs[i].rt_ex;
            RS_ID          = vecs[i].rs_id;
            RT_ID          = vecs[i].rt_id;
            UsesRT_ID      = vecs[i].uses_rt;
            BranchTaken_EX = vecs[i].br;
            MulStart_EX    = vecs[i].mul;
            @(negedge Clk);
            check("vec_ctl",   i, 32'(ctl_now()),   32'(vecs[i].ctl));
            check("vec_stall", i, 32'(StallCycles), 32'(vecs[i].stall));
            check("vec_flush", i, 32'(FlushCount),  32'(vecs[i].flush));
            next_cycle();
        end
        Rst = 1'b0;
        idle_inputs();

        // Reset on the second MUL_WAIT cycle abandons the operation.
        do_reset();
        MulStart_EX = 1'b1;
        @(negedge Clk);
        check("rmul_entry", 0, 32'(ctl_now()), 32'(C_MUL));
        next_cycle();
        MulStart_EX = 1'b0;
        @(negedge Clk);
        check("rmul_wait1", 0, 32'(ctl_now()), 32'(C_MUL));
        next_cycle();
        Rst = 1'b1;
        @(negedge Clk);
        check("rmul_rst_ctl",   0, 32'(ctl_now()),   32'(C_RST));
        check("rmul_pre_stall", 0, 32'(StallCycles), 32'd2);
        next_cycle();
        Rst = 1'b0;
        @(negedge Clk);
        check("rmul_after_ctl",   0, 32'(ctl_now()),   32'(C_DEF));
        check("rmul_after_stall", 0, 32'(StallCycles), 32'd0);
        check("rmul_after_flush", 0, 32'(FlushCount),  32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge Clk);
            check("rmul_no_done", k, 32'(MulDone), 32'd0);
        end
        next_cycle();

        // Stall counter saturation: 20 load-use stalls on a 4-bit counter.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            MemRead_EX = 1'b1; RT_EX = 5'd9; RS_ID = 5'd9;
            next_cycle();
            idle_inputs();
            next_cycle();
        end
        @(negedge Clk);
        check("sat_stall", 0, 32'(StallCycles), 32'd15);

        // Flush counter saturation: 17 consecutive taken branches.
        BranchTaken_EX = 1'b1;
        for (int k = 0; k < 17; k++) begin
            next_cycle();
        end
        BranchTaken_EX = 1'b0;
        @(negedge Clk);
        check("sat_flush",      0, 32'(FlushCount),  32'd15);
        check("sat_stall_hold", 0, 32'(StallCycles), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
